// File: rtl/spi_flash_cmd_slave.sv
// spi_flash_cmd_slave: SPI mode-0 flash command responder.
// Synchronizes sck/cs_n/mosi into sys_clk, shifts single-byte opcodes, and
// models the write-enable latch (WEL) and the bulk-erase busy flag (WIP).
// Optional feature macro: STATUS_READ_EN enables the RDSR (0x05) status read on miso.
module spi_flash_cmd_slave #(
   parameter int SYNC_STAGES  = 2,
   parameter int ERASE_CYCLES = 1000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       sck,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       cmd_err,
   output logic       wel,
   output logic       wip,
   output logic       erase_done
);

   localparam int TW = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_BE   = 8'hC7;
   localparam logic [7:0] OP_RDSR = 8'h05;

   typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_d, cs_d;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_rise, cs_fall;

   state_t                 state;
   logic [7:0]             shreg;
   logic [3:0]             cnt;
   logic [TW-1:0]          timer;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign sck_rise =  sck_s & ~sck_d;
   assign sck_fall = ~sck_s &  sck_d;
   assign cs_rise  =  cs_s  & ~cs_d;
   assign cs_fall  = ~cs_s  &  cs_d;

   // Synchronizer chains plus one delayed copy for edge detection. Cleared to 0 so
   // a reset taken mid-frame (cs_n already low) never manufactures a cs_n fall.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sck_sync  <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_d      <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_s;
         cs_d      <= cs_s;
      end
   end

`ifdef STATUS_READ_EN
   logic       rd_mode;   // current frame opened with RDSR
   logic [7:0] stat_sr;   // status byte snapshot taken at the 8th sck rise
   logic [2:0] rd_idx;    // next status bit to present, MSB first, wraps
   logic [7:0] shreg_nxt;

   assign shreg_nxt = {shreg[6:0], mosi_s};
`else
   assign miso = 1'b0;
`endif

   // Frame FSM, opcode decode, WEL/WIP model and erase timer, all registered.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         timer      <= '0;
         cmd_valid  <= 1'b0;
         cmd_byte   <= '0;
         cmd_err    <= 1'b0;
         wel        <= 1'b0;
         wip        <= 1'b0;
         erase_done <= 1'b0;
`ifdef STATUS_READ_EN
         miso       <= 1'b0;
         rd_mode    <= 1'b0;
         stat_sr    <= '0;
         rd_idx     <= '0;
`endif
      end else begin
         cmd_valid  <= 1'b0;
         cmd_err    <= 1'b0;
         erase_done <= 1'b0;

         // Erase countdown: WIP stays high for exactly ERASE_CYCLES cycles.
         if (wip) begin
            if (timer == '0) begin
               wip        <= 1'b0;
               erase_done <= 1'b1;
            end else begin
               timer <= timer - 1'b1;
            end
         end

         case (state)
            IDLE: begin
`ifdef STATUS_READ_EN
               miso    <= 1'b0;
               rd_mode <= 1'b0;
`endif
               if (cs_fall) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  shreg <= '0;
               end
            end

            SHIFT: begin
               if (sck_rise) begin
                  shreg <= {shreg[6:0], mosi_s};
                  if (cnt != 4'd15) cnt <= cnt + 4'd1;
`ifdef STATUS_READ_EN
                  // Snapshot status once, when the opcode byte completes as RDSR.
                  if (cnt == 4'd7 && shreg_nxt == OP_RDSR) begin
                     rd_mode <= 1'b1;
                     stat_sr <= {6'b0, wel, wip};
                     rd_idx  <= '0;
                  end
`endif
               end
`ifdef STATUS_READ_EN
               // Shift the status out on falling edges so the master samples it on rising ones.
               if (sck_fall && rd_mode) begin
                  miso   <= stat_sr[3'd7 - rd_idx];
                  rd_idx <= rd_idx + 3'd1;
               end
`endif
               if (cs_rise) state <= DECODE;
            end

            DECODE: begin
               state <= IDLE;
`ifdef STATUS_READ_EN
               miso  <= 1'b0;
               if (rd_mode) begin
                  // Status read is accepted with any number of trailing read clocks.
                  cmd_valid <= 1'b1;
                  cmd_byte  <= OP_RDSR;
               end else
`endif
               if (cnt != 4'd8) begin
                  cmd_err <= 1'b1;
               end else begin
                  cmd_valid <= 1'b1;
                  cmd_byte  <= shreg;
                  if (wip) begin
                     cmd_err <= 1'b1;
                  end else begin
                     case (shreg)
                        OP_WREN: wel <= 1'b1;
                        OP_WRDI: wel <= 1'b0;
                        OP_BE: begin
                           if (wel) begin
                              wip   <= 1'b1;
                              wel   <= 1'b0;
                              timer <= TW'(ERASE_CYCLES - 1);
                           end else begin
                              cmd_err <= 1'b1;
                           end
                        end
                        default: cmd_err <= 1'b1;
                     endcase
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_cmd_slave.sv
// Scoreboard bench for spi_flash_cmd_slave: directed scenarios then random frames.
// The reference model tracks WEL/WIP as plain flags and predicts each frame's outcome.
module tb_spi_flash_cmd_slave;

   localparam int E = 1000;

   logic       sys_clk, sys_rst, sck, cs_n, mosi;
   logic       miso, cmd_valid, cmd_err, wel, wip, erase_done;
   logic [7:0] cmd_byte;

   spi_flash_cmd_slave #(.SYNC_STAGES(2), .ERASE_CYCLES(E)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_err(cmd_err),
      .wel(wel), .wip(wip), .erase_done(erase_done)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   typedef struct {
      bit         v;
      bit         e;
      logic [7:0] b;
      bit         wel;
      bit         wip;
   } exp_t;

   exp_t sbq[$];
   exp_t mx;
   int   vectors = 0, miscompares = 0;
   bit   m_wel = 0, m_wip = 0;
   time  erase_end = 0;
   int   n_be = 0, n_abort = 0, n_done = 0;
   int   wip_len = 0;
   bit   wip_abort = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Scoreboard monitor: every cmd pulse consumes one predicted frame outcome.
   always @(negedge sys_clk) begin
      if (!sys_rst && (cmd_valid || cmd_err)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", {30'd0, cmd_valid, cmd_err}, 32'd0);
         end else begin
            mx = sbq.pop_front();
            chk("cmd_valid", cmd_valid, mx.v);
            chk("cmd_err", cmd_err, mx.e);
            if (mx.v) chk("cmd_byte", cmd_byte, mx.b);
            chk("wel", wel, mx.wel);
            chk("wip", wip, mx.wip);
         end
      end
   end

   // Erase monitor: WIP high time and the erase_done pulse at its fall.
   always @(negedge sys_clk) begin
      if (sys_rst) wip_abort = 1;
      if (erase_done) n_done++;
      if (wip === 1'b1) begin
         wip_len++;
      end else begin
         if (wip_len != 0 && !wip_abort) begin
            chk("wip_len", wip_len, E);
            chk("erase_done_at_fall", erase_done, 1);
         end
         wip_len = 0;
         if (!sys_rst) wip_abort = 0;
      end
   end

   // Model: once the predicted erase window is near, wait well past it so frames never straddle it.
   task automatic sync_wip();
      if (m_wip && ($time + 4000 > erase_end - 400)) begin
         while ($time < erase_end + 400) @(posedge sys_clk);
         m_wip = 0;
      end
   endtask

   // Drive one frame of n bits (bits[15] first) and predict its outcome.
   task automatic frame(input logic [15:0] bits, input int n);
      exp_t       x;
      logic [7:0] op, st;
      bit         rd;
      int         c;
      sync_wip();
      op = bits[15:8];
      c  = (n > 15) ? 15 : n;
      rd = 0;
`ifdef STATUS_READ_EN
      rd = (n >= 8) && (op == 8'h05);
`endif
      st = {6'b0, m_wel, m_wip};
      @(negedge sys_clk); #3;
      cs_n = 0;
      #200;
      for (int i = 0; i < n; i++) begin
         mosi = bits[15-i];
         #100;
         if (rd && i >= 8 && i < 16) chk("miso", miso, st[15-i]);
         sck = 1;
         #100;
         sck = 0;
      end
      #200;
      x.v = 0; x.e = 0; x.b = op;
      if (rd) begin
         x.v = 1; x.b = 8'h05;
      end else if (c != 8) begin
         x.e = 1;
      end else begin
         x.v = 1;
         if (m_wip) x.e = 1;
         else if (op == 8'h06) m_wel = 1;
         else if (op == 8'h04) m_wel = 0;
         else if (op == 8'hC7) begin
            if (m_wel) begin
               m_wel = 0; m_wip = 1; n_be++;
               erase_end = $time + E * 20;
            end else x.e = 1;
         end else x.e = 1;
      end
      x.wel = m_wel; x.wip = m_wip;
      sbq.push_back(x);
      cs_n = 1;
      #400;
   endtask

   task automatic rst_pulse();
      @(posedge sys_clk); #2 sys_rst = 1;
      @(posedge sys_clk); #2 sys_rst = 0;
   endtask

   task automatic wait_erase();
      if (m_wip) begin
         while ($time < erase_end + 400) @(posedge sys_clk);
         m_wip = 0;
      end
   endtask

   logic [7:0] rop;
   int         rn, sel;

   initial begin
      sys_rst = 1; cs_n = 1; sck = 0; mosi = 0;
      repeat (5) @(posedge sys_clk);
      #2 sys_rst = 0;
      @(negedge sys_clk);
      chk("rst_miso", miso, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_byte", cmd_byte, 0);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_wel", wel, 0);
      chk("rst_wip", wip, 0);
      chk("rst_erase_done", erase_done, 0);
      #200;

      // BE without WEL, then WREN + BE, WREN rejected while busy, WREN after erase.
      frame({8'hC7, 8'h00}, 8);
      frame({8'h06, 8'h00}, 8);
      frame({8'hC7, 8'h00}, 8);
      frame({8'h06, 8'h00}, 8);
      wait_erase();
      frame({8'h06, 8'h00}, 8);
      // Short frame: 5 bits of 0xA5.
      frame({8'hA5, 8'h00}, 5);
      frame({8'h04, 8'h00}, 8);
`ifdef STATUS_READ_EN
      frame({8'h06, 8'h00}, 8);
      frame({8'hC7, 8'h00}, 8);
      frame({8'h05, 8'h00}, 16);
      wait_erase();
`endif

      // Reset mid-erase and mid-frame.
      frame({8'h06, 8'h00}, 8);
      frame({8'hC7, 8'h00}, 8);
      @(negedge sys_clk); #3;
      cs_n = 0;
      #200;
      for (int i = 0; i < 4; i++) begin
         mosi = i[0]; #100; sck = 1; #100; sck = 0;
      end
      rst_pulse();
      m_wel = 0; m_wip = 0; n_abort++;
      @(negedge sys_clk);
      chk("midrst_wel", wel, 0);
      chk("midrst_wip", wip, 0);
      #100;
      cs_n = 1;
      #400;
      frame({8'h06, 8'h00}, 8);

      // Randomized frames.
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 2)      rop = 8'h06;
         else if (sel == 3) rop = 8'h04;
         else if (sel <= 5) rop = 8'hC7;
         else if (sel <= 7) rop = 8'h05;
         else               rop = 8'($urandom);
         if (rop == 8'h05) rn = ($urandom_range(0, 1) != 0) ? 16 : 8;
         else if ($urandom_range(0, 5) == 0) rn = $urandom_range(1, 12);
         else rn = 8;
         frame({rop, 8'($urandom)}, rn);
      end

      wait_erase();
      #1000;
      chk("sb_empty", sbq.size(), 0);
      chk("erase_done_count", n_done, n_be - n_abort);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
